core_sequencer: RTL and testbench

- Instruction sequencer for a single GPU core: holds a small program of core opcodes and issues them with the `execute` strobe, one per cycle.
- Re-runs the program for a configurable number of passes. After each pass it samples the core's `accu_lsb` and shifts it into a result word.
- Sits between the frame/pixel control logic (start/done) and one core instance.
- Output feeds the pixel path, e.g. one grayscale value per run.

---
 rtl/core_sequencer.sv | 157 +++++++++++++++
 tb/tb_core_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Instruction sequencer for one GPU core: issues a stored opcode program for PASSES passes and
// shifts the core's accu_lsb into a result word after each pass. Optional stall via CORE_SEQ_STALL_EN.
module core_sequencer #(
  parameter int OPCODE_W   = 14,
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int PASSES     = 8
) (
  input  logic                clk,
  input  logic                reset,
`ifdef CORE_SEQ_STALL_EN
  input  logic                stall,
`endif
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [OPCODE_W-1:0] prog_data,
  input  logic [ADDR_W:0]     prog_len,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [PASSES-1:0]   result,
  output logic [OPCODE_W-1:0] opcode,
  output logic                execute,
  input  logic                accu_lsb
);

  // state    | meaning
  // S_IDLE   | waiting for start, program memory writable
  // S_RUN    | issuing mem[pc] with execute, one instruction per cycle
  // S_SAMPLE | pass finished, capture accu_lsb into result
  // S_DONE   | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SAMPLE, S_DONE} state_t;

  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
  localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d, pc_inc;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic [ADDR_W:0]       len_q, len_d, len_m1;
  logic [PASSES-1:0]     result_q, result_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic                  exec_q, exec_d;
  logic                  hold;

  logic [OPCODE_W-1:0]   mem [PROG_DEPTH];

`ifdef CORE_SEQ_STALL_EN
  assign hold = stall && ((state_q == S_RUN) || (state_q == S_SAMPLE));
`else
  assign hold = 1'b0;
`endif

  assign pc_inc = pc_q + PC_ONE;
  assign len_m1 = len_q - LEN_ONE;

  // Program memory is deliberately left out of reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE))
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      pass_q   <= '0;
      len_q    <= '0;
      result_q <= '0;
      opcode_q <= '0;
      exec_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pass_q   <= pass_d;
      len_q    <= len_d;
      result_q <= result_d;
      opcode_q <= opcode_d;
      exec_q   <= exec_d;
    end
  end

  // opcode/execute are computed for the next cycle so they leave the block registered.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pass_d   = pass_q;
    len_d    = len_q;
    result_d = result_q;
    opcode_d = opcode_q;
    exec_d   = exec_q;
    case (state_q)
      S_IDLE: begin
        opcode_d = '0;
        exec_d   = 1'b0;
        if (start && (prog_len != '0)) begin
          len_d    = prog_len;
          pc_d     = '0;
          pass_d   = '0;
          result_d = '0;
          opcode_d = mem['0];
          exec_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (!hold) begin
          if ({1'b0, pc_q} == len_m1) begin
            opcode_d = '0;
            exec_d   = 1'b0;
            state_d  = S_SAMPLE;
          end else begin
            pc_d     = pc_inc;
            opcode_d = mem[pc_inc];
            exec_d   = 1'b1;
          end
        end
      end
      S_SAMPLE: begin
        if (!hold) begin
          result_d = {result_q[PASSES-2:0], accu_lsb};
          if (pass_q == PASS_LAST) begin
            opcode_d = '0;
            exec_d   = 1'b0;
            state_d  = S_DONE;
          end else begin
            pass_d   = pass_q + PASS_W'(1);
            pc_d     = '0;
            opcode_d = mem['0];
            exec_d   = 1'b1;
            state_d  = S_RUN;
          end
        end
      end
      S_DONE: begin
        opcode_d = '0;
        exec_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        opcode_d = '0;
        exec_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // A stalled instruction stays on opcode but is not strobed until the stall drops.
  assign execute = exec_q && !hold;
  assign opcode  = opcode_q;
  assign result  = result_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: timing, result shifting, write/start lockout,
// async reset mid-run and, when CORE_SEQ_STALL_EN is defined, stall behaviour.
module tb_core_sequencer;
  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [13:0] prog_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic [13:0] opcode;
  logic        execute;
  logic        accu_lsb;
`ifdef CORE_SEQ_STALL_EN
  logic        stall;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [13:0] exp_mem [16];

  core_sequencer #(.OPCODE_W(14), .PROG_DEPTH(16), .ADDR_W(4), .PASSES(8)) dut (
    .clk(clk),
    .reset(reset),
`ifdef CORE_SEQ_STALL_EN
    .stall(stall),
`endif
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_len(prog_len),
    .start(start),
    .busy(busy),
    .done(done),
    .result(result),
    .opcode(opcode),
    .execute(execute),
    .accu_lsb(accu_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [3:0] addr, input logic [13:0] data);
    prog_we = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we = 1'b0;
    exp_mem[addr] = data;
  endtask

  // Caller sets prog_len and start=1 before this; returns in the cycle after done.
  task automatic run_prog(input int len, input logic [7:0] bits, input bit disturb, input bit hold);
    logic [7:0] exp_res;
    int c0;
    exp_res = '0;
    c0 = cyc;
    tick();
    if (!hold) start = 1'b0;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < len; i++) begin
        chk("run_execute", execute, 1);
        chk("run_opcode", opcode, exp_mem[i]);
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        if (disturb && p == 1 && i == 0) begin
          prog_we = 1'b1; prog_addr = 4'd0; prog_data = 14'h3FFF; start = 1'b1; prog_len = 5'd1;
        end else if (disturb && p == 1 && i == 1) begin
          prog_we = 1'b0; start = 1'b0;
        end
        tick();
      end
      accu_lsb = bits[7-p];
      chk("sample_execute", execute, 0);
      chk("sample_opcode", opcode, 0);
      chk("sample_result", result, exp_res);
      exp_res = {exp_res[6:0], bits[7-p]};
      tick();
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_execute", execute, 0);
    chk("done_cycle", cyc - c0, (len + 1) * 8 + 1);
    chk("done_result", result, bits);
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_result", result, bits);
  endtask

  initial begin
    reset = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; accu_lsb = 1'b0;
`ifdef CORE_SEQ_STALL_EN
    stall = 1'b0;
`endif
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_execute", execute, 0);
    tick();
    #2 reset = 1'b0;
    tick();

    write_mem(4'd0, 14'h0001);
    write_mem(4'd1, 14'h0002);
    write_mem(4'd2, 14'h0003);
    prog_len = 5'd3; start = 1'b1;
    run_prog(3, 8'hB2, 1'b0, 1'b0);

    prog_len = 5'd0; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("len0_busy", busy, 0);
      chk("len0_execute", execute, 0);
      chk("len0_done", done, 0);
    end
    chk("len0_result_held", result, 8'hB2);
    start = 1'b0;

    prog_len = 5'd3; start = 1'b1;
    run_prog(3, 8'h6D, 1'b1, 1'b0);
    prog_len = 5'd3;

    write_mem(4'd0, 14'h3FFF);
    for (int k = 3; k < 16; k++) write_mem(4'(k), 14'(k * 14'h0111));
    prog_len = 5'd16; start = 1'b1;
    run_prog(16, 8'h5A, 1'b0, 1'b0);

    prog_len = 5'd3; start = 1'b1;
    run_prog(3, 8'hFF, 1'b0, 1'b1);
    tick();
    chk("rehold_execute", execute, 1);
    chk("rehold_opcode", opcode, 14'h3FFF);
    start = 1'b0;
    repeat (9) tick();
    chk("mid_result", result, 8'h03);
    chk("mid_execute", execute, 1);
    chk("mid_opcode", opcode, 14'h0002);
    reset = 1'b1;
    #1;
    chk("arst_opcode", opcode, 0);
    chk("arst_execute", execute, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    chk("arst_done", done, 0);
    #2 reset = 1'b0;
    tick();
    tick();
    chk("after_rst_busy", busy, 0);

    start = 1'b1;
    run_prog(3, 8'h0F, 1'b0, 1'b0);

`ifdef CORE_SEQ_STALL_EN
    begin
      int c0;
      bit seen;
      write_mem(4'd0, 14'h0001);
      accu_lsb = 1'b0;
      prog_len = 5'd3; start = 1'b1;
      c0 = cyc;
      tick();
      start = 1'b0;
      chk("st_op1", opcode, 14'h0001);
      chk("st_ex1", execute, 1);
      tick();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("st_hold_execute", execute, 0);
        chk("st_hold_opcode", opcode, 14'h0002);
        tick();
      end
      stall = 1'b0;
      #1;
      chk("st_op2", opcode, 14'h0002);
      chk("st_ex2", execute, 1);
      tick();
      chk("st_op3", opcode, 14'h0003);
      chk("st_ex3", execute, 1);
      tick();
      chk("st_sample", execute, 0);
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
        tick();
        if (done) seen = 1'b1;
      end
      chk("st_done_seen", seen, 1);
      chk("st_done_cycle", cyc - c0, 36);
      tick();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
